// File: rtl/stopwatch_timekeeper.sv
// Stopwatch time source: prescaled elapsed minutes/seconds with start/stop,
// clear and lap-freeze control, feeding the multiplexed display driver.
module stopwatch_timekeeper #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int MAX_MINUTES = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       running,
  output logic       lap_active,
  output logic       rollover
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [PW-1:0] presc;
  logic [6:0]    live_min;
  logic [6:0]    live_sec;
  logic [6:0]    lap_min;
  logic [6:0]    lap_sec;
  logic          tick;
  logic          wrap;
  logic [6:0]    min_nx;
  logic [6:0]    sec_nx;

  // One-second advance of a minutes:seconds pair, wrapping MAX_MINUTES:59 to 00:00.
  function automatic logic [13:0] advance(input logic [6:0] m, input logic [6:0] s);
    if (s != 7'd59)
      return {m, s + 7'd1};
    else if (m != 7'(MAX_MINUTES))
      return {m + 7'd1, 7'd0};
    else
      return 14'd0;
  endfunction

  always_comb begin
    tick   = (state == RUNNING) && (presc == PW'(TICK_DIV - 1));
    wrap   = tick && (live_sec == 7'd59) && (live_min == 7'(MAX_MINUTES));
    min_nx = live_min;
    sec_nx = live_sec;
    if (tick)
      {min_nx, sec_nx} = advance(live_min, live_sec);
    state_nx = state;
    if (start_stop) begin
      case (state)
        IDLE:    state_nx = RUNNING;
        RUNNING: state_nx = PAUSED;
        PAUSED:  state_nx = RUNNING;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      state      <= IDLE;
      presc      <= '0;
      live_min   <= '0;
      live_sec   <= '0;
      lap_active <= 1'b0;
      running    <= 1'b0;
      rollover   <= 1'b0;
      if (!reset) begin
        lap_min <= '0;
        lap_sec <= '0;
      end
    end else begin
      // The prescaler only advances while running so a pause keeps the sub-second phase.
      if (state == RUNNING)
        presc <= tick ? '0 : presc + 1'b1;
      live_min <= min_nx;
      live_sec <= sec_nx;
      rollover <= wrap;
      state    <= state_nx;
      running  <= (state_nx == RUNNING);
      if (lap) begin
        if (lap_active) begin
          lap_active <= 1'b0;
        end else if (state == RUNNING) begin
          lap_min    <= min_nx;
          lap_sec    <= sec_nx;
          lap_active <= 1'b1;
        end
      end
    end
  end

  assign minutes = lap_active ? lap_min : live_min;
  assign seconds = lap_active ? lap_sec : live_sec;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// Bench for stopwatch_timekeeper: vector table, directed corner sequences and
// randomized control pulses compared against an elapsed-time reference model.
module tb_stopwatch_timekeeper;

  localparam int TD   = 4;
  localparam int MAXM = 99;
  localparam int SPAN = (MAXM + 1) * 60;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [6:0] minutes;
  logic [6:0] seconds;
  logic       running;
  logic       lap_active;
  logic       rollover;

  int checks = 0;
  int errors = 0;

  stopwatch_timekeeper #(.TICK_DIV(TD), .MAX_MINUTES(MAXM)) dut (
    .clock(clock), .reset(reset), .start_stop(start_stop), .clear(clear), .lap(lap),
    .minutes(minutes), .seconds(seconds), .running(running),
    .lap_active(lap_active), .rollover(rollover)
  );

  always #5 clock = ~clock;

  // Reference model: elapsed running cycles define the time; mode 0=idle 1=run 2=paused.
  int m_mode = 0;
  int m_cycles = 0;
  int m_lap_total = 0;
  bit m_lap_act = 0;
  bit m_roll = 0;

  function automatic int m_total();
    return (m_cycles / TD) % SPAN;
  endfunction

  task automatic model_edge(input bit r, input bit ss, input bit clr, input bit lp);
    bit was_run;
    bit tick;
    if (!r || clr) begin
      m_mode = 0; m_cycles = 0; m_lap_act = 0; m_roll = 0;
      if (!r) m_lap_total = 0;
      return;
    end
    was_run = (m_mode == 1);
    if (was_run) m_cycles++;
    tick = was_run && (m_cycles % TD == 0);
    m_roll = tick && (m_total() == 0);
    if (lp) begin
      if (m_lap_act) m_lap_act = 0;
      else if (was_run) begin m_lap_act = 1; m_lap_total = m_total(); end
    end
    if (ss) m_mode = (m_mode == 1) ? 2 : 1;
  endtask

  function automatic logic [16:0] model_out();
    int t;
    t = m_lap_act ? m_lap_total : m_total();
    return {7'(t / 60), 7'(t % 60), (m_mode == 1), m_lap_act, m_roll};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] dut_out();
    return {minutes, seconds, running, lap_active, rollover};
  endfunction

  // Drive one cycle of inputs, clock it, then compare DUT against the model.
  task automatic step(input bit r, input bit ss, input bit clr, input bit lp, input string name);
    reset = r; start_stop = ss; clear = clr; lap = lp;
    @(posedge clock);
    model_edge(r, ss, clr, lp);
    #1;
    check(name, 32'(dut_out()), 32'(model_out()));
    reset = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, name);
  endtask

  typedef struct {
    bit         r, ss, clr, lp;
    logic [6:0] min, sec;
    bit         run, lact, roll;
  } vec_t;

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 0, 1, 0, 0};
    vecs[2]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    vecs[5]  = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
    vecs[6]  = '{1, 0, 0, 1, 0, 1, 1, 1, 0};
    vecs[7]  = '{1, 0, 0, 0, 0, 1, 1, 1, 0};
    vecs[8]  = '{1, 0, 0, 0, 0, 1, 1, 1, 0};
    vecs[9]  = '{1, 0, 0, 0, 0, 1, 1, 1, 0};
    vecs[10] = '{1, 1, 0, 1, 0, 2, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 1, 0, 2, 0, 0, 0};
    vecs[12] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};

    #2;
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].ss, vecs[i].clr, vecs[i].lp, "vec_model");
      check($sformatf("vec%0d", i), 32'(dut_out()),
            32'({vecs[i].min, vecs[i].sec, vecs[i].run, vecs[i].lact, vecs[i].roll}));
    end

    // 240 cycles of running gives exactly one minute.
    step(0, 0, 0, 0, "t1_rst"); step(0, 0, 0, 0, "t1_rst");
    check("t1_reset_out", 32'(dut_out()), 32'd0);
    step(1, 1, 0, 0, "t1_start");
    idle(3, "t1_run");
    check("t1_sec_before_tick", 32'(seconds), 32'd0);
    step(1, 0, 0, 0, "t1_tick");
    check("t1_first_tick", 32'(seconds), 32'd1);
    idle(236, "t1_run");
    check("t1_one_minute", 32'({minutes, seconds, running}), 32'({7'd1, 7'd0, 1'b1}));

    // Pause keeps the sub-second phase.
    step(0, 0, 0, 0, "t2_rst");
    step(1, 1, 0, 0, "t2_start");
    idle(5, "t2_run");
    step(1, 1, 0, 0, "t2_pause");
    check("t2_paused", 32'({seconds, running}), 32'({7'd1, 1'b0}));
    idle(100, "t2_hold");
    check("t2_held", 32'(seconds), 32'd1);
    step(1, 1, 0, 0, "t2_resume");
    step(1, 0, 0, 0, "t2_r1");
    check("t2_resume_plus1", 32'(seconds), 32'd1);
    step(1, 0, 0, 0, "t2_r2");
    check("t2_resume_plus2", 32'(seconds), 32'd2);

    // Full-range wrap with a single-cycle rollover pulse.
    step(0, 0, 0, 0, "t3_rst");
    step(1, 1, 0, 0, "t3_start");
    idle(SPAN * TD - 1, "t3_run");
    check("t3_at_max", 32'({minutes, seconds, rollover}), 32'({7'd99, 7'd59, 1'b0}));
    step(1, 0, 0, 0, "t3_wrap");
    check("t3_wrapped", 32'(dut_out()), 32'({7'd0, 7'd0, 1'b1, 1'b0, 1'b1}));
    step(1, 0, 0, 0, "t3_after");
    check("t3_roll_clear", 32'({rollover, running}), 32'({1'b0, 1'b1}));

    // Lap freeze and release.
    step(0, 0, 0, 0, "t4_rst");
    step(1, 1, 0, 0, "t4_start");
    idle(19, "t4_run");
    step(1, 0, 0, 1, "t4_lap");
    check("t4_frozen", 32'({seconds, lap_active}), 32'({7'd5, 1'b1}));
    idle(20, "t4_hold");
    check("t4_still_frozen", 32'({minutes, seconds, lap_active}), 32'({7'd0, 7'd5, 1'b1}));
    step(1, 0, 0, 1, "t4_release");
    check("t4_released", 32'({minutes, seconds, lap_active}), 32'({7'd0, 7'd10, 1'b0}));

    // Clear beats start_stop.
    step(0, 0, 0, 0, "t5_rst");
    step(1, 1, 0, 0, "t5_start");
    idle(28, "t5_run");
    check("t5_at7", 32'(seconds), 32'd7);
    step(1, 1, 1, 0, "t5_clear");
    check("t5_cleared", 32'(dut_out()), 32'd0);
    idle(8, "t5_idle");
    check("t5_stays_idle", 32'(dut_out()), 32'd0);

    // Reset mid-run with a lap frozen.
    step(1, 1, 0, 0, "t6_start");
    idle(83 * TD - 1, "t6_run");
    step(1, 0, 0, 1, "t6_lap");
    check("t6_lap_123", 32'({minutes, seconds, lap_active}), 32'({7'd1, 7'd23, 1'b1}));
    step(0, 0, 0, 0, "t6_reset");
    check("t6_all_zero", 32'(dut_out()), 32'd0);
    step(1, 1, 0, 0, "t6_restart");
    idle(TD, "t6_run");
    check("t6_from_zero", 32'({minutes, seconds, running}), 32'({7'd0, 7'd1, 1'b1}));

    // Randomized control pulses against the model.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 149) == 0), ($urandom_range(0, 14) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
